// File: rtl/fixed_point_display.sv
// fixed_point_display: sequential double-dabble of a Q1.9.6 word into sign plus five
// decimal digits, scanned onto a 6-position common-anode seven-segment display.
module fixed_point_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] ZERO = 7'b1000000;
    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;
    state_t state, next_state;
    logic [15:0] cap, shown_val, mag;
    logic [6:0] hund;
    logic [3:0] step;
    logic [9:0] int_sh, frac_sh;
    logic [11:0] int_bcd;
    logic [7:0] frac_bcd;
    logic [6:0] dig [6];
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic start, busy_nxt, wrap;
    function automatic logic [3:0] adj(input logic [3:0] n);
        return n >= 4'd5 ? n + 4'd3 : n;
    endfunction
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction
    // 16-bit negation of 0x8000 wraps to 0x8000, which read unsigned is the 32768 we need
    assign mag = result[15] ? 16'(-result) : result;
    assign hund = 7'((13'(mag[5:0]) * 13'd100) >> 6);
    assign start = state == IDLE && result != shown_val;
    assign wrap = cnt == CW'(REFRESH_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state == SHIFT ? (step == 4'd9 ? UPDATE : SHIFT) : (start ? SHIFT : IDLE);
    end
    always_comb begin
        busy_nxt = state != IDLE || start;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cap <= '0;
            shown_val <= '0;
            step <= '0;
            int_sh <= '0;
            frac_sh <= '0;
            int_bcd <= '0;
            frac_bcd <= '0;
            dig <= '{BLANK, BLANK, BLANK, ZERO, ZERO, ZERO};
        end else begin
            busy <= busy_nxt;
            if (start) begin
                cap <= result;
                step <= '0;
                int_sh <= mag[15:6];
                frac_sh <= {3'b000, hund};
                int_bcd <= '0;
                frac_bcd <= '0;
            end
            if (state == SHIFT) begin
                step <= step + 4'd1;
                int_bcd <= 12'({adj(int_bcd[11:8]), adj(int_bcd[7:4]), adj(int_bcd[3:0]), int_sh[9]});
                frac_bcd <= 8'({adj(frac_bcd[7:4]), adj(frac_bcd[3:0]), frac_sh[9]});
                int_sh <= int_sh << 1;
                frac_sh <= frac_sh << 1;
            end
            if (state == UPDATE) begin
                shown_val <= cap;
                dig[0] <= cap[15] ? MINUS : BLANK;
                dig[1] <= int_bcd[11:8] == 4'd0 ? BLANK : seg_of(int_bcd[11:8]);
                dig[2] <= int_bcd[11:4] == 8'd0 ? BLANK : seg_of(int_bcd[7:4]);
                dig[3] <= seg_of(int_bcd[3:0]);
                dig[4] <= seg_of(frac_bcd[7:4]);
                dig[5] <= seg_of(frac_bcd[3:0]);
            end
        end
    end
    // Outputs are registered from whole digit registers, so a scan never mixes old and new sets
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            an <= '1;
            seg <= BLANK;
            dp <= 1'b1;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            an <= ~(6'b100000 >> idx);
            seg <= dig[idx];
            dp <= idx != 3'd3;
        end
    end
endmodule

// File: tb/tb_fixed_point_display.sv
// tb_fixed_point_display: random and directed stimulus checked each cycle against an
// arithmetic model of the conversion timing, blanking rules and scan position.
module tb_fixed_point_display;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] result = 16'h0000;
    logic busy, dp;
    logic [6:0] seg;
    logic [5:0] an;
    int tests = 0;
    int fails = 0;
    fixed_point_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .result(result),
        .busy(busy), .seg(seg), .dp(dp), .an(an)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int pos);
        int m, ip, hu;
        m = v[15] ? 65536 - int'(v) : int'(v);
        ip = m / 64;
        hu = (m % 64) * 100 / 64;
        case (pos)
            0: return v[15] ? 7'b0111111 : 7'b1111111;
            1: return ip < 100 ? 7'b1111111 : code(ip / 100);
            2: return ip < 10 ? 7'b1111111 : code((ip / 10) % 10);
            3: return code(ip % 10);
            4: return code(hu / 10);
            default: return code(hu % 10);
        endcase
    endfunction
    int k, t_cap, pos;
    logic active, mvalid = 1'b0;
    logic [15:0] shown_m, disp, cap_v;
    logic e_busy, e_dp;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    always @(posedge clk) begin
        mvalid = 1'b1;
        if (!rst_n) begin
            k = 0;
            active = 1'b0;
            shown_m = '0;
            disp = '0;
            e_busy = 1'b0;
            e_an = 6'b111111;
            e_seg = 7'b1111111;
            e_dp = 1'b1;
        end else begin
            pos = (k / DIV) % 6;
            e_an = ~(6'b100000 >> pos);
            e_seg = exp_seg(disp, pos);
            e_dp = pos != 3;
            if (active) begin
                e_busy = 1'b1;
                if (k - t_cap == 11) begin
                    disp = cap_v;
                    shown_m = cap_v;
                    active = 1'b0;
                end
            end else if (result != shown_m) begin
                active = 1'b1;
                t_cap = k;
                cap_v = result;
                e_busy = 1'b1;
            end else e_busy = 1'b0;
            k++;
        end
    end
    always @(negedge clk) begin
        if (mvalid) begin
            check("busy", busy, e_busy);
            check("an", an, e_an);
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
        end
    end
    initial begin
        int n;
        logic seen;
        logic [15:0] vals [4] = '{16'hFFA0, 16'h0001, 16'h7FFF, 16'h8000};
        check("pin_neg_sign", exp_seg(16'hFFA0, 0), 7'b0111111);
        check("pin_neg_ones", exp_seg(16'hFFA0, 3), 7'b1111001);
        check("pin_neg_tenths", exp_seg(16'hFFA0, 4), 7'b0010010);
        check("pin_max_hundredths", exp_seg(16'h7FFF, 5), 7'b0000000);
        check("pin_max_tenths", exp_seg(16'h7FFF, 4), 7'b0010000);
        check("pin_min_hundreds", exp_seg(16'h8000, 1), 7'b0010010);
        check("pin_min_sign", exp_seg(16'h8000, 0), 7'b0111111);
        check("pin_small_hundredths", exp_seg(16'h0001, 5), 7'b1111001);
        check("pin_small_tens", exp_seg(16'h0001, 2), 7'b1111111);
        check("pin_five_tens", exp_seg(16'h0140, 2), 7'b1111111);
        repeat (3) @(negedge clk);
        check("reset_an", an, 6'b111111);
        rst_n = 1'b1;
        @(negedge clk);
        check("an_first", an, 6'b011111);
        check("busy_idle", busy, 1'b0);
        repeat (30) @(negedge clk);
        result = 16'h0140;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("busy_len", n, 12);
        seen = 1'b0;
        for (int i = 0; i < 6 * DIV + 2 && !seen; i++) begin
            @(negedge clk);
            if (an == 6'b111011) seen = 1'b1;
        end
        check("ones_seen", seen, 1'b1);
        check("ones_five", seg, 7'b0010010);
        check("ones_dp", dp, 1'b0);
        foreach (vals[i]) begin
            result = vals[i];
            repeat (14 + 6 * DIV) @(negedge clk);
        end
        result = 16'h0140;
        repeat (4) @(negedge clk);
        result = 16'h00A0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("b2b_busy", n, 20);
        result = 16'h1234;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_an", an, 6'b111111);
        check("rst_seg", seg, 7'b1111111);
        rst_n = 1'b1;
        repeat (14 + 6 * DIV) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            result = 16'($urandom);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        repeat (14 + 6 * DIV) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
